// File: rtl/simon_pkg.sv
`default_nettype none
// ============================================================================
// Module   : simon_pkg
// Purpose  : Shared Simon Says types, LFSR tap mask and step one-hot helper.
// Revision : 1.0 - initial release
// ============================================================================
package simon_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ADD      = 3'd1,
    S_SHOW_ON  = 3'd2,
    S_SHOW_OFF = 3'd3,
    S_INPUT    = 3'd4,
    S_WIN      = 3'd5,
    S_LOSE     = 3'd6
  } seq_state_t;

  typedef logic [3:0] step_t;

  // Taps 16,14,13,11 of a right-shifting Fibonacci register land on bits 0,2,3,5
  localparam logic [15:0] c_lfsr_taps = 16'h002D;

  function automatic step_t onehot4(input logic [1:0] code);
    return step_t'(4'b0001 << code);
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_gen_if
// Purpose  : Game control / playback / comparator-enable bundle of seq_gen.
// Revision : 1.0 - initial release
// ============================================================================
interface seq_gen_if
  import simon_pkg::*;
#(
  parameter int MAX_LEN = 16
);
  localparam int LVL_W = $clog2(MAX_LEN) + 1;

  logic             start;
  logic             sw_valid;
  logic             correct_input;
  step_t            leds;
  step_t            actual;
  logic             on_off;
  logic [LVL_W-1:0] level;
  logic             win;
  logic             lose;

  modport master (
    input  start, sw_valid, correct_input,
    output leds, actual, on_off, level, win, lose
  );

  modport slave (
    output start, sw_valid, correct_input,
    input  leds, actual, on_off, level, win, lose
  );
endinterface
`default_nettype wire

// File: rtl/seq_gen_lfsr16.sv
`default_nettype none
// ============================================================================
// Module   : lfsr16
// Purpose  : Free-running 16-bit Fibonacci LFSR; exposes the 2-bit step code.
// Revision : 1.0 - initial release
// ============================================================================
module lfsr16
  import simon_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  wire logic       clk,
  input  wire logic       reset,
  output logic      [1:0] o_code
);

  logic [15:0] r_lfsr;
  logic        w_fb;

  assign w_fb   = ^(r_lfsr & c_lfsr_taps);
  assign o_code = r_lfsr[1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lfsr <= SEED;
    end else begin
      r_lfsr <= {w_fb, r_lfsr[15:1]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/seq_gen.sv
`default_nettype none
// ============================================================================
// Module   : seq_gen
// Purpose  : Simon Says sequence grower, LED playback and answer sequencer.
//            Optional build macro SEQ_GEN_SPEEDUP_EN halves playback timing
//            every four levels.
// Revision : 1.0 - initial release
// ============================================================================
module seq_gen
  import simon_pkg::*;
#(
  parameter int          MAX_LEN     = 16,
  parameter int          SHOW_CYCLES = 25_000_000,
  parameter int          GAP_CYCLES  = 12_500_000,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  wire logic  clk,
  input  wire logic  reset,
  seq_gen_if.master  bus
);

  localparam int LVL_W = $clog2(MAX_LEN) + 1;
  localparam int IDX_W = $clog2(MAX_LEN);
  localparam logic [31:0] c_show = 32'(SHOW_CYCLES);
  localparam logic [31:0] c_gap  = 32'(GAP_CYCLES);

  seq_state_t       r_state, w_state_nxt;
  logic [LVL_W-1:0] r_level, w_level_nxt;
  logic [IDX_W-1:0] r_idx,   w_idx_nxt;
  logic [31:0]      r_cnt,   w_cnt_nxt;
  logic             w_mem_we;
  logic [1:0]       r_mem [MAX_LEN];
  logic [1:0]       w_code;
  logic             w_last;
  logic [31:0]      w_show_dur;
  logic [31:0]      w_gap_dur;
  step_t            w_step;

  lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .o_code (w_code)
  );

`ifdef SEQ_GEN_SPEEDUP_EN
  logic [LVL_W-1:0] w_shift;
  logic [31:0]      w_show_raw;
  logic [31:0]      w_gap_raw;

  assign w_shift    = r_level >> 2;
  assign w_show_raw = c_show >> w_shift;
  assign w_gap_raw  = c_gap >> w_shift;
  assign w_show_dur = (w_show_raw == 32'd0) ? 32'd1 : w_show_raw;
  assign w_gap_dur  = (w_gap_raw == 32'd0) ? 32'd1 : w_gap_raw;
`else
  assign w_show_dur = (c_show == 32'd0) ? 32'd1 : c_show;
  assign w_gap_dur  = (c_gap == 32'd0) ? 32'd1 : c_gap;
`endif

  assign w_last = ({1'b0, r_idx} == (r_level - LVL_W'(1)));

  always_comb begin
    w_state_nxt = r_state;
    w_level_nxt = r_level;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_mem_we    = 1'b0;
    case (r_state)
      S_ADD: begin
        w_mem_we    = 1'b1;
        w_level_nxt = r_level + LVL_W'(1);
        w_idx_nxt   = '0;
        w_cnt_nxt   = '0;
        w_state_nxt = S_SHOW_ON;
      end
      S_SHOW_ON: begin
        if (r_cnt == w_show_dur - 32'd1) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_SHOW_OFF;
        end else begin
          w_cnt_nxt = r_cnt + 32'd1;
        end
      end
      S_SHOW_OFF: begin
        if (r_cnt == w_gap_dur - 32'd1) begin
          w_cnt_nxt = '0;
          if (w_last) begin
            w_idx_nxt   = '0;
            w_state_nxt = S_INPUT;
          end else begin
            w_idx_nxt   = r_idx + IDX_W'(1);
            w_state_nxt = S_SHOW_ON;
          end
        end else begin
          w_cnt_nxt = r_cnt + 32'd1;
        end
      end
      S_INPUT: begin
        if (bus.sw_valid) begin
          if (!bus.correct_input) begin
            w_state_nxt = S_LOSE;
          end else if (!w_last) begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end else if (r_level == LVL_W'(MAX_LEN)) begin
            w_state_nxt = S_WIN;
          end else begin
            w_state_nxt = S_ADD;
          end
        end
      end
      default: ;
    endcase
    // A new game pre-empts everything, including an answer in the same cycle
    if (bus.start) begin
      w_state_nxt = S_ADD;
      w_level_nxt = '0;
      w_idx_nxt   = '0;
      w_cnt_nxt   = '0;
      w_mem_we    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_level <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_level <= w_level_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[r_level[IDX_W-1:0]] <= w_code;
    end
  end

  // Outputs decode only flops, so they move solely on state / idx updates
  assign w_step     = onehot4(r_mem[r_idx]);
  assign bus.leds   = (r_state == S_SHOW_ON) ? w_step : 4'd0;
  assign bus.actual = (r_state == S_INPUT) ? w_step : 4'd0;
  assign bus.on_off = (r_state == S_INPUT);
  assign bus.win    = (r_state == S_WIN);
  assign bus.lose   = (r_state == S_LOSE);
  assign bus.level  = (r_state == S_IDLE || r_state == S_WIN || r_state == S_LOSE)
                      ? '0 : r_level;

endmodule
`default_nettype wire
